// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_pkg;

   localparam int DIGITS = 4;

   typedef logic [7:0] seg_pattern_t;

   // Active-low segments: all ones means every segment is dark.
   localparam seg_pattern_t SEG_BLANK = 8'hFF;

   typedef enum logic [1:0] {
      IDLE,
      BLANK,
      ON
   } state_t;

endpackage

// File: rtl/seg_frame_buffer.sv
// Double buffer for the digit patterns: host writes land in a shadow copy
// and only reach the display outputs at a frame boundary (or right away
// when the scanner is idle), so a frame never shows a half-updated set.
module seg_frame_buffer
   import seg_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         upd,
   input  logic         commit,
   input  logic         idle,
   input  seg_pattern_t data_a,
   input  seg_pattern_t data_b,
   input  seg_pattern_t data_c,
   input  seg_pattern_t data_d,
   output logic         busy,
   output seg_pattern_t seg_a,
   output seg_pattern_t seg_b,
   output seg_pattern_t seg_c,
   output seg_pattern_t seg_d
);

   seg_pattern_t [DIGITS-1:0] shadow;
   seg_pattern_t [DIGITS-1:0] shown;
   logic                      take;

   // The commit copies the shadow as it stood before this edge, so an upd
   // landing on the same edge is kept for the next frame instead.
   assign take = busy && (commit || idle);

   // Shadow capture, commit to the display copy, and the pending flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow <= {DIGITS{SEG_BLANK}};
         shown  <= {DIGITS{SEG_BLANK}};
         busy   <= 1'b0;
      end else begin
         if (take) shown <= shadow;
         if (upd) shadow <= {data_d, data_c, data_b, data_a};
         busy <= upd || (busy && !take);
      end
   end

   assign seg_a = shown[0];
   assign seg_b = shown[1];
   assign seg_c = shown[2];
   assign seg_d = shown[3];

endmodule

// File: rtl/seg_scan_controller.sv
// Scan sequencer for a four-digit seven-segment display: slot timing,
// inter-digit blanking against ghosting, PWM brightness inside each
// on-window, and a frame-synchronous pattern buffer.
module seg_scan_controller
   import seg_pkg::*;
#(
   parameter int SLOT_CYCLES  = 1000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic [3:0]        brightness,
   input  logic              upd,
   input  seg_pattern_t      data_a,
   input  seg_pattern_t      data_b,
   input  seg_pattern_t      data_c,
   input  seg_pattern_t      data_d,
   output logic              busy,
   output logic [DIGITS-1:0] select,
   output logic              mux_enable,
   output seg_pattern_t      seg_a,
   output seg_pattern_t      seg_b,
   output seg_pattern_t      seg_c,
   output seg_pattern_t      seg_d,
   output logic              frame_tick
);

   localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
   // With no blanking the slot opens directly in ON.
   localparam state_t SLOT_START = (BLANK_CYCLES > 0) ? BLANK : ON;

   state_t              state, nxt_state;
   logic [CNT_W-1:0]    cnt, nxt_cnt;
   logic [3:0]          pwm, nxt_pwm;
   logic [DIGITS-1:0]   nxt_sel;

   // Next slot position; outputs are then registered from these values so
   // nothing is combinational from inputs to outputs.
   always_comb begin
      nxt_state = state;
      nxt_cnt   = cnt;
      nxt_pwm   = pwm;
      nxt_sel   = select;
      if (!run) begin
         nxt_state = IDLE;
         nxt_cnt   = '0;
         nxt_pwm   = '0;
      end else if (state == IDLE) begin
         nxt_state = SLOT_START;
         nxt_cnt   = '0;
         nxt_pwm   = '0;
         nxt_sel   = DIGITS'(1);
      end else if (cnt == SLOT_LAST) begin
         nxt_state = SLOT_START;
         nxt_cnt   = '0;
         nxt_pwm   = '0;
         nxt_sel   = {select[DIGITS-2:0], select[DIGITS-1]};
      end else begin
         nxt_cnt = cnt + CNT_W'(1);
         if (state == BLANK && cnt == BLANK_LAST) begin
            nxt_state = ON;
            nxt_pwm   = '0;
         end else if (state == ON) begin
            nxt_pwm = pwm + 4'd1;
         end
      end
   end

   // Scan FSM with registered enable, select and frame tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         pwm        <= '0;
         select     <= DIGITS'(1);
         mux_enable <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         state      <= nxt_state;
         cnt        <= nxt_cnt;
         pwm        <= nxt_pwm;
         select     <= nxt_sel;
         mux_enable <= (nxt_state == ON) && (brightness == 4'hF || nxt_pwm < brightness);
         frame_tick <= (nxt_state != IDLE) && nxt_sel[DIGITS-1] && (nxt_cnt == SLOT_LAST);
      end
   end

   seg_frame_buffer u_buf (
      .clk    (clk),
      .rst    (rst),
      .upd    (upd),
      .commit (frame_tick),
      .idle   (state == IDLE),
      .data_a (data_a),
      .data_b (data_b),
      .data_c (data_c),
      .data_d (data_d),
      .busy   (busy),
      .seg_a  (seg_a),
      .seg_b  (seg_b),
      .seg_c  (seg_c),
      .seg_d  (seg_d)
   );

endmodule

// File: tb/tb_seg_scan_controller.sv
// Bench for seg_scan_controller: a cycle-level reference model computes the
// expected outputs from elapsed scan time and pushes them to a queue; a
// monitor on the falling edge pops and compares against the DUT.
module tb_seg_scan_controller;

   localparam int SLOT = 8;
   localparam int BLNK = 2;

   logic       clk = 1'b0;
   logic       rst, run, upd;
   logic [3:0] brightness;
   logic [7:0] data_a, data_b, data_c, data_d;
   logic       busy, mux_enable, frame_tick;
   logic [3:0] select;
   logic [7:0] seg_a, seg_b, seg_c, seg_d;

   always #5 clk = ~clk;

   seg_scan_controller #(.SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLNK)) dut (
      .clk(clk), .rst(rst), .run(run), .brightness(brightness), .upd(upd),
      .data_a(data_a), .data_b(data_b), .data_c(data_c), .data_d(data_d),
      .busy(busy), .select(select), .mux_enable(mux_enable),
      .seg_a(seg_a), .seg_b(seg_b), .seg_c(seg_c), .seg_d(seg_d),
      .frame_tick(frame_tick)
   );

   typedef struct packed {
      logic [3:0]  sel;
      logic        en;
      logic        tick;
      logic        busy;
      logic [31:0] seg;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;

   // Reference model: scan position is just elapsed cycles since run rose.
   int          m_t = -1;
   int          m_dig = 0;
   logic [31:0] m_disp = '1, m_shadow = '1;
   logic        m_pend = 1'b0, m_tick = 1'b0, m_en = 1'b0;

   initial begin
      forever begin
         exp_t e;
         int   pos;
         @(posedge clk);
         if (rst) begin
            m_t = -1; m_dig = 0; m_disp = '1; m_shadow = '1;
            m_pend = 1'b0; m_tick = 1'b0; m_en = 1'b0;
         end else begin
            if (m_pend && (m_tick || m_t < 0)) begin
               m_disp = m_shadow;
               m_pend = 1'b0;
            end
            if (upd) begin
               m_shadow = {data_d, data_c, data_b, data_a};
               m_pend = 1'b1;
            end
            m_t = run ? m_t + 1 : -1;
            if (m_t < 0) begin
               m_en = 1'b0;
               m_tick = 1'b0;
            end else begin
               pos   = m_t % SLOT;
               m_dig = (m_t / SLOT) % 4;
               m_en  = (pos >= BLNK) && (brightness == 4'hF || ((pos - BLNK) % 16) < int'(brightness));
               m_tick = (m_dig == 3) && (pos == SLOT - 1);
            end
         end
         e.sel  = 4'(1 << m_dig);
         e.en   = m_en;
         e.tick = m_tick;
         e.busy = m_pend;
         e.seg  = m_disp;
         q.push_back(e);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   // Monitor: outputs are registered, so every cycle presents a new sample.
   initial begin
      forever begin
         exp_t e;
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("select", 32'(select), 32'(e.sel));
            chk("mux_enable", 32'(mux_enable), 32'(e.en));
            chk("frame_tick", 32'(frame_tick), 32'(e.tick));
            chk("busy", 32'(busy), 32'(e.busy));
            chk("seg", {seg_d, seg_c, seg_b, seg_a}, e.seg);
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_upd(input logic [31:0] d);
      {data_d, data_c, data_b, data_a} = d;
      upd = 1'b1;
      cyc(1);
      upd = 1'b0;
   endtask

   task automatic wait_tick();
      int k = 0;
      while (frame_tick !== 1'b1 && k < 100) begin
         cyc(1);
         k++;
      end
      if (k >= 100) begin
         tests++; fails++;
         $display("FAIL wait_tick: no frame_tick within 100 cycles, expected one per 32");
      end
   endtask

   task automatic wait_sel(input logic [3:0] s);
      int k = 0;
      while (select !== s && k < 100) begin
         cyc(1);
         k++;
      end
      if (k >= 100) begin
         tests++; fails++;
         $display("FAIL wait_sel: select stuck at %h, expected %h", select, s);
      end
   endtask

   initial begin
      int idle_left = 0;
      rst = 1'b1; run = 1'b0; upd = 1'b0; brightness = 4'd0;
      {data_d, data_c, data_b, data_a} = '0;
      cyc(3);
      rst = 1'b0;
      cyc(2);

      // Full brightness scanning
      run = 1'b1; brightness = 4'd15;
      cyc(70);
      // Partial and zero duty
      brightness = 4'd3;
      cyc(40);
      brightness = 4'd0;
      cyc(20);
      brightness = 4'd15;

      // Mid-frame update commits at the next frame boundary
      wait_sel(4'h2);
      pulse_upd(32'hF6A4B096);
      cyc(40);

      // Update on the tick edge waits a frame; a later update overwrites it
      wait_tick();
      pulse_upd(32'h11223344);
      cyc(10);
      pulse_upd(32'h55667788);
      cyc(70);

      // Run drops in digit C's on-window, then restarts
      wait_sel(4'h4);
      cyc(4);
      run = 1'b0;
      cyc(5);
      run = 1'b1;
      cyc(20);

      // Reset while an update is pending
      wait_sel(4'h2);
      pulse_upd(32'hDEADBEEF);
      cyc(3);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      cyc(40);

      // Update while idle commits on the following edge
      run = 1'b0;
      cyc(2);
      pulse_upd(32'hC0FFEE01);
      cyc(4);
      run = 1'b1;

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 29) == 0) brightness = 4'($urandom);
         if (idle_left > 0) begin
            idle_left--;
            run = 1'b0;
         end else begin
            run = 1'b1;
            if ($urandom_range(0, 99) == 0) idle_left = $urandom_range(1, 6);
         end
         upd = ($urandom_range(0, 15) == 0);
         {data_d, data_c, data_b, data_a} = $urandom;
         rst = ($urandom_range(0, 599) == 0);
         cyc(1);
      end
      upd = 1'b0; rst = 1'b0;
      cyc(3);
      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
